// File: rtl/fx3_sf_pkg.sv
// Shared definitions for the FX3 slave-FIFO 2-bit controllers (stream-IN writer
// and stream-OUT reader): FSM state encoding, pin/flag polarities, default
// buffer geometry and socket addresses.
package fx3_sf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_PKTEND  = 3'd3,
    ST_HOLDOFF = 3'd4
  } sf_state_e;

  // Slave-FIFO control pins are active low.
  localparam logic PIN_ACT  = 1'b0;
  localparam logic PIN_IDLE = 1'b1;

  // Flag levels meaning "OK to keep writing".
  localparam logic FLAGC_ABOVE_WM = 1'b1;
  localparam logic FLAGD_NOT_FULL = 1'b1;

  // Default buffer geometry: 1024 x 32-bit = 4 KB FX3 buffer.
  localparam int DEF_PKT_WORDS   = 1024;
  localparam int DEF_DRAIN_WORDS = 3;
  localparam int DEF_HOLDOFF_CYC = 3;

  // Socket addresses shared between the IN writer and the OUT reader.
  localparam logic [1:0] SOCK_IN_ADDR  = 2'b00;
  localparam logic [1:0] SOCK_OUT_ADDR = 2'b11;

endpackage

// File: rtl/fx3_stream_in_wr_ctrl.sv
// Stream-IN write controller for the FX3 slave FIFO (2-bit address mode).
// Takes producer words over valid/ready and writes them to the IN socket,
// throttling on the watermark (flagc) and full (flagd) flags and committing
// short packets with pktend. All FX3-facing pins are registered.
module fx3_stream_in_wr_ctrl
  import fx3_sf_pkg::*;
#(
  parameter int         DATA_W      = 32,
  parameter logic [1:0] FADDR       = SOCK_IN_ADDR,
  parameter int         PKT_WORDS   = DEF_PKT_WORDS,
  parameter int         DRAIN_WORDS = DEF_DRAIN_WORDS,
  parameter int         HOLDOFF_CYC = DEF_HOLDOFF_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] fdata,
  output logic [1:0]        faddr,
  output logic              slcs,
  output logic              slwr,
  output logic              sloe,
  output logic              pktend,
  input  logic              flagc,
  input  logic              flagd,
  output logic [15:0]       pkt_count,
  output logic              wr_err
);

  localparam logic [15:0] LAST_IDX   = 16'(PKT_WORDS - 1);
  localparam logic [7:0]  DRAIN_LOAD = 8'(DRAIN_WORDS);
  localparam logic [7:0]  HOLD_LOAD  = 8'(HOLDOFF_CYC - 1);

  sf_state_e   state, state_n;
  logic        flagc_q, flagd_q;
  logic [15:0] word_cnt;
  logic [7:0]  drain_cnt;
  logic [7:0]  hold_cnt;

  logic space_ok, not_full;
  logic acc, at_last, full_wrap, short_commit, flush_commit;

  assign faddr = FADDR;
  assign sloe  = PIN_IDLE;

  // ---- stage p0 -> p1: flag inputs registered once, all decisions use _q ----
  // Register the FX3 flags so every decision sees a clean, clocked copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      flagc_q <= ~FLAGC_ABOVE_WM;
      flagd_q <= ~FLAGD_NOT_FULL;
    end else begin
      flagc_q <= flagc;
      flagd_q <= flagd;
    end
  end

  assign space_ok = (flagc_q == FLAGC_ABOVE_WM);
  assign not_full = (flagd_q == FLAGD_NOT_FULL);

  // Ready depends only on registered state and flags; commit decisions follow.
  // A flush alongside an accepted word ends the packet on that word, so only
  // one pktend is ever issued for it.
  always_comb begin
    s_ready = 1'b0;
    case (state)
      ST_WRITE: s_ready = not_full && space_ok;
      ST_DRAIN: s_ready = not_full && (drain_cnt != 8'd0);
      default:  s_ready = 1'b0;
    endcase
  end

  assign acc          = s_valid && s_ready;
  assign at_last      = (word_cnt == LAST_IDX);
  assign full_wrap    = acc && at_last;
  assign short_commit = acc && !at_last && (s_last || flush);
  assign flush_commit = flush && !acc && (word_cnt != 16'd0);

  // Next-state selection; packet commits override the flag-driven moves.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (enable && space_ok) state_n = ST_WRITE;
      ST_WRITE: begin
        if (!not_full)      state_n = ST_HOLDOFF;
        else if (!space_ok) state_n = ST_DRAIN;
        else if (!enable)   state_n = ST_IDLE;
      end
      ST_DRAIN: begin
        if (!not_full)                                  state_n = ST_HOLDOFF;
        else if ((drain_cnt == 8'd0) ||
                 (acc && (drain_cnt == 8'd1)))          state_n = ST_HOLDOFF;
      end
      ST_PKTEND:  state_n = ST_HOLDOFF;
      ST_HOLDOFF: if (hold_cnt == 8'd0) state_n = (enable && space_ok) ? ST_WRITE : ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
    if (short_commit)      state_n = ST_PKTEND;
    else if (flush_commit) state_n = ST_HOLDOFF;
  end

  // ---- stage p1: control state, counters and sticky error ----
  // FSM, word/drain/holdoff counters, committed-packet count and wr_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      word_cnt  <= '0;
      drain_cnt <= '0;
      hold_cnt  <= '0;
      pkt_count <= '0;
      wr_err    <= 1'b0;
    end else begin
      state <= state_n;

      if (full_wrap || short_commit || flush_commit) word_cnt <= '0;
      else if (acc)                                  word_cnt <= word_cnt + 16'd1;

      if (full_wrap || short_commit || flush_commit) pkt_count <= pkt_count + 16'd1;

      // DRAIN is only entered from WRITE, so the budget is reloaded there.
      if (state == ST_WRITE)                drain_cnt <= DRAIN_LOAD;
      else if (state == ST_DRAIN && acc)    drain_cnt <= drain_cnt - 8'd1;

      // Holdoff restarts on every fresh entry, including a flush inside it.
      if (state != ST_HOLDOFF || flush_commit) hold_cnt <= HOLD_LOAD;
      else if (hold_cnt != 8'd0)               hold_cnt <= hold_cnt - 8'd1;

      if (slwr == PIN_ACT && !not_full) wr_err <= 1'b1;
    end
  end

  // ---- stage p1 -> pins: registered FX3 strobes and data ----
  // Chip select stays low while a final strobe is still on the pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      slwr   <= PIN_IDLE;
      pktend <= PIN_IDLE;
      slcs   <= PIN_IDLE;
      fdata  <= '0;
    end else begin
      slwr   <= acc ? PIN_ACT : PIN_IDLE;
      pktend <= (short_commit || flush_commit) ? PIN_ACT : PIN_IDLE;
      slcs   <= ((state_n == ST_IDLE) && !acc) ? PIN_IDLE : PIN_ACT;
      if (acc) fdata <= s_data;
    end
  end

endmodule
